// File: rtl/rv_instr_encoder_pkg.sv
// Shared RV32I instruction constants and the encoder field bundle.
package rv_instr_encoder_pkg;

    // opcode[6:2] for the classes the core decodes
    typedef enum logic [4:0] {
        ClassOpImm  = 5'b00100,
        ClassOp     = 5'b01100,
        ClassLui    = 5'b01101,
        ClassBranch = 5'b11000
    } instr_class_e;

    localparam logic [1:0] OpcodeSuffix = 2'b11;

    localparam logic [2:0] Funct3Add  = 3'b000;
    localparam logic [2:0] Funct3Sll  = 3'b001;
    localparam logic [2:0] Funct3Slt  = 3'b010;
    localparam logic [2:0] Funct3Sltu = 3'b011;
    localparam logic [2:0] Funct3Srx  = 3'b101;

    localparam logic [6:0] Funct7Zero = 7'b0000000;
    localparam logic [6:0] Funct7Alt  = 7'b0100000;

    typedef struct packed {
        logic [4:0]  cls;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } instr_fields_t;

endpackage

// File: rtl/rv_instr_pack.sv
// Combinational RV32I field packer: bundle in, instruction word and legality flag out.
import rv_instr_encoder_pkg::*;

module rv_instr_pack (
    input  instr_fields_t fields,
    output logic [31:0]   word,
    output logic          illegal
);

    logic [6:0] opcode;
    logic       is_shift;

    always_comb begin
        opcode   = {fields.cls, OpcodeSuffix};
        is_shift = (fields.funct3 == Funct3Sll) || (fields.funct3 == Funct3Srx);
        word     = '0;
        illegal  = 1'b0;
        case (fields.cls)
            ClassOp: begin
                word = {fields.funct7, fields.rs2, fields.rs1, fields.funct3, fields.rd, opcode};
                if (fields.funct7 == Funct7Alt) begin
                    illegal = !((fields.funct3 == Funct3Add) || (fields.funct3 == Funct3Srx));
                end else begin
                    illegal = (fields.funct7 != Funct7Zero);
                end
            end
            ClassOpImm: begin
                if (is_shift) begin
                    word = {fields.funct7, fields.imm[4:0], fields.rs1, fields.funct3,
                            fields.rd, opcode};
                end else begin
                    word = {fields.imm[11:0], fields.rs1, fields.funct3, fields.rd, opcode};
                end
                if (fields.funct3 == Funct3Sll) begin
                    illegal = (fields.funct7 != Funct7Zero);
                end else if (fields.funct3 == Funct3Srx) begin
                    illegal = (fields.funct7 != Funct7Zero) && (fields.funct7 != Funct7Alt);
                end
            end
            ClassBranch: begin
                word = {fields.imm[12], fields.imm[10:5], fields.rs2, fields.rs1, fields.funct3,
                        fields.imm[4:1], fields.imm[11], opcode};
                illegal = (fields.funct3 == Funct3Slt) || (fields.funct3 == Funct3Sltu) ||
                          fields.imm[0];
            end
            ClassLui: begin
                word = {fields.imm[31:12], fields.rd, opcode};
            end
            default: begin
                // Unknown classes fall back to the R-type layout so they still encode verbatim
                word    = {fields.funct7, fields.rs2, fields.rs1, fields.funct3, fields.rd, opcode};
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/rv_instr_encoder.sv
// RV32I instruction encoder with a registered valid/ready IMEM write port.
// Define RV_ENC_ILLEGAL_TRAP_EN to drop illegal bundles and raise the sticky err flag.
import rv_instr_encoder_pkg::*;

module rv_instr_encoder #(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned DEPTH     = 1024
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [4:0]                   in_class,
    input  logic [2:0]                   in_funct3,
    input  logic [6:0]                   in_funct7,
    input  logic [4:0]                   in_rd,
    input  logic [4:0]                   in_rs1,
    input  logic [4:0]                   in_rs2,
    input  logic [31:0]                  in_imm,
    output logic                         mem_valid,
    input  logic                         mem_ready,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [31:0]                  mem_wdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         err
);

    localparam int unsigned       CountW   = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
    localparam logic [CountW:0]   DepthExt = (CountW + 1)'(DEPTH);

    instr_fields_t     fields;
    logic [31:0]       word;
    logic              illegal;
    logic              accept;
    logic              load;
    logic              write_fire;
    logic [CountW:0]   pending;

    logic              mem_valid_q, mem_valid_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [CountW-1:0] count_q, count_d;

    always_comb begin
        fields.cls    = in_class;
        fields.funct3 = in_funct3;
        fields.funct7 = in_funct7;
        fields.rd     = in_rd;
        fields.rs1    = in_rs1;
        fields.rs2    = in_rs2;
        fields.imm    = in_imm;
    end

    rv_instr_pack u_pack (
        .fields  (fields),
        .word    (word),
        .illegal (illegal)
    );

    // Words already written plus the one held in the output register
    assign pending    = {1'b0, count_q} + {{CountW{1'b0}}, mem_valid_q};
    assign in_ready   = (pending < DepthExt) && (!mem_valid_q || mem_ready);
    assign accept     = in_valid && in_ready;
    assign write_fire = mem_valid_q && mem_ready;

`ifdef RV_ENC_ILLEGAL_TRAP_EN
    logic err_q;

    assign load = accept && !illegal;
    assign err  = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (clear) begin
            err_q <= 1'b0;
        end else if (accept && illegal) begin
            err_q <= 1'b1;
        end
    end
`else
    logic unused_illegal;

    assign unused_illegal = illegal;
    assign load           = accept;
    assign err            = 1'b0;
`endif

    always_comb begin
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        count_d     = count_q;
        if (clear) begin
            mem_valid_d = 1'b0;
            mem_addr_d  = BaseAddr;
            count_d     = '0;
        end else begin
            if (write_fire) begin
                mem_valid_d = 1'b0;
                mem_addr_d  = mem_addr_q + ADDR_W'(4);
                count_d     = count_q + CountW'(1);
            end
            if (load) begin
                mem_valid_d = 1'b1;
                mem_wdata_d = word;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid_q <= 1'b0;
            mem_addr_q  <= BaseAddr;
            mem_wdata_q <= '0;
            count_q     <= '0;
        end else begin
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            count_q     <= count_d;
        end
    end

    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign count     = count_q;
    assign full      = (count_q == CountW'(DEPTH));

endmodule

// File: doc/rv_instr_encoder.md
Name: rv_instr_encoder

Overview:
- Inverse of the core's instruction decode: takes field bundles (opcode class, funct3, funct7, rd, rs1, rs2, imm) and produces RV32I instruction words.
- Covers exactly the classes the core decodes: OP, OPIMM, BRANCH, LUI.
- Encoded words go out through a registered valid/ready write port into instruction memory, at sequential word addresses.
- Used by the test harness and the boot loader to build programs in IMEM.

Parameters:
- ADDR_W, 12, byte-address width of the IMEM write port.
- BASE_ADDR, 0, first byte address written after reset or clear. Must be word aligned.
- DEPTH, 1024, max words writable before full. Must be ≤ 2^(ADDR_W-2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- clear  in  1  sync: address back to BASE_ADDR, count=0, err=0, output register invalidated.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  bundle accepted when in_valid&&in_ready.
- in_class  in  5  opcode[6:2] class code (OP, OPIMM, BRANCH, LUI).
- in_funct3  in  3  funct3.
- in_funct7  in  7  funct7; for shift-immediates, imm[11:5].
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_imm  in  32  immediate, sign-extended value: I uses [11:0]; B uses [12:1], [0] must be 0; U uses [31:12].
- mem_valid  out  1  write request.
- mem_ready  in  1  IMEM accepts the write.
- mem_addr  out  ADDR_W  byte address.
- mem_wdata  out  32  encoded instruction.
- count  out  $clog2(DEPTH+1)  words written since reset/clear.
- full  out  1  count==DEPTH.
- err  out  1  sticky illegal-bundle flag.

Behaviour:
- Reset (async, rst_n=0): mem_valid=0, mem_addr=BASE_ADDR, mem_wdata=0, count=0, full=0, err=0. Reset mid-transfer abandons the pending word; no partial write.
- Opcode: {in_class,2'b11}.
- R-type (OP): {funct7,rs2,rs1,funct3,rd,opcode}.
- I-type (OPIMM): {imm[11:0],rs1,funct3,rd,opcode}.
- Shift-immediates (OPIMM with funct3=001/101): {funct7,imm[4:0],rs1,funct3,rd,opcode}.
- B-type (BRANCH): {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}.
- U-type (LUI): {imm[31:12],rd,opcode}.
- Illegal bundles:
  - class not in {OP,OPIMM,BRANCH,LUI};
  - OP funct7 not 0000000/0100000;
  - OP funct7=0100000 with funct3 not 000/101;
  - OPIMM funct3=001 with funct7≠0;
  - OPIMM funct3=101 with funct7 not 0000000/0100000;
  - BRANCH funct3 010 or 011;
  - BRANCH imm[0]=1.
- Pipeline: a single output register. A bundle accepted in cycle N gives mem_valid=1 in cycle N+1.
- in_ready = !full_next && (!mem_valid || mem_ready). A word accepted by IMEM and a new bundle accepted in the same cycle is allowed (full throughput).
- mem_valid/addr/wdata stay stable while mem_valid&&!mem_ready.
- On a write handshake: mem_addr += 4, count += 1. Address wraps modulo 2^ADDR_W.
- full asserts the cycle count reaches DEPTH. in_ready is then 0 until clear/reset. Acceptance that would exceed DEPTH counts words accepted but not yet written.
- clear has priority over simultaneous handshakes in the same cycle; that in-flight bundle is dropped.

Optional Feature:
- RV_ENC_ILLEGAL_TRAP_EN defined: illegal bundles are accepted (in_ready handshake completes) but dropped. No mem write, no count change, err set sticky.
- Not defined: no legality check. Fields are encoded verbatim and written. err is tied 0.

Decomposition:
- Class codes (OP, OPIMM, BRANCH, LUI), funct3/funct7 constants, and a packed typedef for the field bundle go in the shared instruction package. Add a 2-bit opcode-suffix constant 2'b11 there.
- One combinational sub-module, rv_instr_pack: bundle in, 32-bit word plus illegal flag out. The top holds the output register, address/count logic and handshakes.

Test Plan:
- ADD x1,x2,x3 (OP,f3=0,f7=0) then SUB x5,x6,x7 (f7=0100000) back-to-back with mem_ready=1 -> writes 0x003100B3 @0x000 and 0x407302B3 @0x004 on consecutive cycles, count=2.
- ADDI x1,x0,5 -> 0x00500093; SRAI x1,x2,3 (f3=101,f7=0100000,imm=3) -> 0x40315093.
- BEQ x1,x2,+8 -> 0x00208463; LUI x5,imm=0x12345000 -> 0x123452B7.
- Hold mem_ready=0 for 3 cycles with a second bundle offered -> mem_wdata/mem_addr stable, in_ready=0. Release -> both words written in order, no loss or duplication.
- DEPTH=4: offer 6 bundles -> full=1 after the 4th write, in_ready=0. clear -> mem_addr=BASE_ADDR, count=0, full=0.
- With RV_ENC_ILLEGAL_TRAP_EN: BRANCH f3=010 and BEQ with imm=7 -> both accepted, no writes, err=1, count unchanged. Without the macro -> words written and err stays 0.
